// File: rtl/servo_ramp.sv
// servo_ramp: slew-rate limiter in front of the SG90 PWM generator.
// It accepts a target pulse width over a valid/ready handshake and clamps
// it to the safe servo range. It then walks the registered setPwm output
// toward that target in bounded steps, one step every stepDiv+1 clocks.
module servo_ramp #(
  parameter logic [7:0] PWM_MIN = 8'd13,
  parameter logic [7:0] PWM_MAX = 8'd26,
  parameter logic [7:0] HOME    = 8'd19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tgtValid,
  output logic        tgtReady,
  input  logic [7:0]  tgtPwm,
  input  logic [3:0]  stepSize,
  input  logic [23:0] stepDiv,
  output logic [7:0]  setPwm,
  output logic        busy,
  output logic        done,
  output logic        clampErr
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  setpwm_q, setpwm_d;
  logic [7:0]  target_q, target_d;
  logic [3:0]  step_q, step_d;
  logic [23:0] div_q, div_d;
  logic [23:0] tick_q, tick_d;
  logic        done_q, done_d;
  logic        clamp_err_q, clamp_err_d;
  logic        ready_q, busy_q;

  logic [7:0]        clamped_s;
  logic              out_of_range_s;
  logic signed [8:0] diff_s;
  logic [8:0]        mag_s;

  // Limit a requested pulse width to the legal servo window.
  function automatic logic [7:0] clamp_pwm(input logic [7:0] v);
    logic [7:0] r;
    if (v < PWM_MIN) begin
      r = PWM_MIN;
    end else if (v > PWM_MAX) begin
      r = PWM_MAX;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Report whether a requested pulse width falls outside the legal window.
  function automatic logic pwm_out_of_range(input logic [7:0] v);
    return (v < PWM_MIN) || (v > PWM_MAX);
  endfunction

  // Clamp the incoming command and form the signed distance to the target.
  always_comb begin
    clamped_s      = clamp_pwm(tgtPwm);
    out_of_range_s = pwm_out_of_range(tgtPwm);
    diff_s         = $signed({1'b0, target_q}) - $signed({1'b0, setpwm_q});
    if (diff_s[8]) begin
      mag_s = 9'(-diff_s);
    end else begin
      mag_s = 9'(diff_s);
    end
  end

  // Next-state, step and pulse logic of the IDLE/RAMP controller.
  always_comb begin
    state_d     = state_q;
    setpwm_d    = setpwm_q;
    target_d    = target_q;
    step_d      = step_q;
    div_d       = div_q;
    tick_d      = tick_q;
    done_d      = 1'b0;
    clamp_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tgtValid) begin
          target_d    = clamped_s;
          clamp_err_d = out_of_range_s;
          step_d      = (stepSize == 4'd0) ? 4'd1 : stepSize;
          div_d       = stepDiv;
          tick_d      = 24'd0;
          if (clamped_s == setpwm_q) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RAMP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (tick_q == div_q) begin
          tick_d = 24'd0;
          if (mag_s <= {5'd0, step_q}) begin
            // Remaining distance fits in one step: land exactly on target.
            setpwm_d = target_q;
            state_d  = ST_IDLE;
            done_d   = 1'b1;
          end else if (diff_s[8]) begin
            setpwm_d = setpwm_q - {4'd0, step_q};
          end else begin
            setpwm_d = setpwm_q + {4'd0, step_q};
          end
        end else begin
          tick_d = tick_q + 24'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset parks the servo at HOME immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      setpwm_q    <= HOME;
      target_q    <= HOME;
      step_q      <= 4'd1;
      div_q       <= 24'd0;
      tick_q      <= 24'd0;
      done_q      <= 1'b0;
      clamp_err_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      setpwm_q    <= setpwm_d;
      target_q    <= target_d;
      step_q      <= step_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      clamp_err_q <= clamp_err_d;
      ready_q     <= (state_d == ST_IDLE);
      busy_q      <= (state_d == ST_RAMP);
    end
  end

  assign setPwm   = setpwm_q;
  assign tgtReady = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign clampErr = clamp_err_q;

endmodule
